memory_access_unit: RTL and testbench

Memory (MEM) pipeline stage. It consumes the registered execution-stage outputs: ALU result, zero flag, branch target and the rt store data. It resolves taken branches, performs load/store accesses to the data memory through a req/ack handshake, and produces registered write-back data for the WB stage. It stalls upstream stages while a memory access is outstanding.

---
 rtl/memory_access_unit.sv | 246 ++++++++++++++++++++++++
 tb/tb_memory_access_unit.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_unit.sv
// MEM pipeline stage: branch resolution, ALU pass-through and byte-lane load/store
// over a req/ack data-memory port with an ack timeout and sticky error flag.
module memory_access_unit #(
   parameter int NB_ADDR        = 5,
   parameter int NB_DATA        = 2**NB_ADDR,
   parameter int NB_WIDTH_SEL   = 2,
   parameter int NB_TIMEOUT     = 4,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic                    i_clock,
   input  logic                    i_reset_n,
   input  logic                    i_valid,
   input  logic [NB_DATA-1:0]      i_alu_result,
   input  logic                    i_alu_zero,
   input  logic [NB_DATA-1:0]      i_branch_addr,
   input  logic [NB_DATA-1:0]      i_rt_data,
   input  logic                    i_branch,
   input  logic                    i_mem_read,
   input  logic                    i_mem_write,
   input  logic [NB_WIDTH_SEL-1:0] i_mem_width,
   input  logic                    i_load_signed,
   input  logic                    i_dmem_ack,
   input  logic [NB_DATA-1:0]      i_dmem_rdata,
   output logic                    o_dmem_req,
   output logic                    o_dmem_we,
   output logic [NB_DATA-1:0]      o_dmem_addr,
   output logic [NB_DATA-1:0]      o_dmem_wdata,
   output logic [3:0]              o_dmem_be,
   output logic                    o_stall,
   output logic                    o_pc_src,
   output logic [NB_DATA-1:0]      o_branch_target,
   output logic [NB_DATA-1:0]      o_wb_data,
   output logic                    o_wb_valid,
   output logic                    o_misaligned,
   output logic                    o_mem_error
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_WAIT = 1'b1;

   localparam logic [NB_WIDTH_SEL-1:0] W_BYTE = NB_WIDTH_SEL'(0);
   localparam logic [NB_WIDTH_SEL-1:0] W_HALF = NB_WIDTH_SEL'(1);
   localparam logic [NB_WIDTH_SEL-1:0] W_WORD = NB_WIDTH_SEL'(2);

   localparam logic [NB_TIMEOUT-1:0] CNT_LAST = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

   logic [0:0]              state_q, state_d;
   logic [NB_TIMEOUT-1:0]   cnt_q, cnt_d;
   logic                    req_q, req_d;
   logic                    we_q, we_d;
   logic [NB_DATA-1:0]      addr_q, addr_d;
   logic [NB_DATA-1:0]      wdata_q, wdata_d;
   logic [3:0]              be_q, be_d;
   logic                    pc_src_q, pc_src_d;
   logic [NB_DATA-1:0]      target_q, target_d;
   logic [NB_DATA-1:0]      wb_data_q, wb_data_d;
   logic                    wb_valid_q, wb_valid_d;
   logic                    misaligned_q, misaligned_d;
   logic                    mem_error_q, mem_error_d;
   logic                    ld_load_q, ld_load_d;
   logic                    ld_signed_q, ld_signed_d;
   logic [NB_WIDTH_SEL-1:0] ld_width_q, ld_width_d;
   logic [1:0]              ld_lane_q, ld_lane_d;

   logic [1:0]         lane_k;
   logic               is_mem_op;
   logic               aligned;
   logic               accept;
   logic               timeout_now;
   logic [3:0]         store_be;
   logic [7:0]         lane_byte [4];
   logic [NB_DATA-1:0] store_wdata;
   logic [NB_DATA-1:0] load_shifted;
   logic [NB_DATA-1:0] load_data;

   assign lane_k    = i_alu_result[1:0];
   assign is_mem_op = i_valid & ~i_branch & (i_mem_read | i_mem_write);

   always_comb begin
      case (i_mem_width)
         W_BYTE:  aligned = 1'b1;
         W_HALF:  aligned = ~lane_k[0];
         W_WORD:  aligned = (lane_k == 2'b00);
         default: aligned = 1'b0;
      endcase
   end

   assign accept      = (state_q == ST_IDLE) & is_mem_op & aligned;
   assign timeout_now = (state_q == ST_WAIT) & ~i_dmem_ack & (cnt_q == CNT_LAST);

   // The abort cycle releases the stall just like an ack cycle, so the dropped op retires.
   assign o_stall = i_reset_n &
                    (accept | ((state_q == ST_WAIT) & ~i_dmem_ack & ~timeout_now));

   always_comb begin
      case (i_mem_width)
         W_BYTE:  store_be = 4'b0001 << lane_k;
         W_HALF:  store_be = 4'b0011 << lane_k;
         default: store_be = 4'b1111;
      endcase
   end

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_byte[gi] = (i_mem_width == W_BYTE) ? i_rt_data[7:0] :
                             (i_mem_width == W_HALF) ? i_rt_data[8*(gi%2) +: 8] :
                                                       i_rt_data[8*gi +: 8];
   end
   assign store_wdata = {lane_byte[3], lane_byte[2], lane_byte[1], lane_byte[0]};

   // Load extraction uses attributes latched at issue, not the live inputs.
   assign load_shifted = i_dmem_rdata >> {ld_lane_q, 3'b000};

   always_comb begin
      case (ld_width_q)
         W_BYTE:  load_data = {{(NB_DATA-8){ld_signed_q & load_shifted[7]}}, load_shifted[7:0]};
         W_HALF:  load_data = {{(NB_DATA-16){ld_signed_q & load_shifted[15]}}, load_shifted[15:0]};
         default: load_data = load_shifted;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      req_d        = req_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      be_d         = be_q;
      pc_src_d     = 1'b0;
      target_d     = target_q;
      wb_data_d    = wb_data_q;
      wb_valid_d   = 1'b0;
      misaligned_d = 1'b0;
      mem_error_d  = mem_error_q;
      ld_load_d    = ld_load_q;
      ld_signed_d  = ld_signed_q;
      ld_width_d   = ld_width_q;
      ld_lane_d    = ld_lane_q;

      case (state_q)
         ST_IDLE: begin
            if (i_valid) begin
               if (i_branch) begin
                  if (i_alu_zero) begin
                     pc_src_d = 1'b1;
                     target_d = i_branch_addr;
                  end
               end else if (i_mem_read | i_mem_write) begin
                  if (aligned) begin
                     state_d     = ST_WAIT;
                     cnt_d       = '0;
                     req_d       = 1'b1;
                     we_d        = i_mem_write;
                     addr_d      = {i_alu_result[NB_DATA-1:2], 2'b00};
                     wdata_d     = store_wdata;
                     be_d        = store_be;
                     ld_load_d   = ~i_mem_write;
                     ld_signed_d = i_load_signed;
                     ld_width_d  = i_mem_width;
                     ld_lane_d   = lane_k;
                  end else begin
                     misaligned_d = 1'b1;
                  end
               end else begin
                  wb_data_d  = i_alu_result;
                  wb_valid_d = 1'b1;
               end
            end
         end
         default: begin
            if (i_dmem_ack) begin
               state_d = ST_IDLE;
               req_d   = 1'b0;
               we_d    = 1'b0;
               be_d    = 4'b0000;
               if (ld_load_q) begin
                  wb_data_d  = load_data;
                  wb_valid_d = 1'b1;
               end
            end else if (timeout_now) begin
               state_d     = ST_IDLE;
               cnt_d       = cnt_q + 1'b1;
               req_d       = 1'b0;
               we_d        = 1'b0;
               be_d        = 4'b0000;
               mem_error_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         req_q        <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         be_q         <= 4'b0000;
         pc_src_q     <= 1'b0;
         target_q     <= '0;
         wb_data_q    <= '0;
         wb_valid_q   <= 1'b0;
         misaligned_q <= 1'b0;
         mem_error_q  <= 1'b0;
         ld_load_q    <= 1'b0;
         ld_signed_q  <= 1'b0;
         ld_width_q   <= '0;
         ld_lane_q    <= 2'b00;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         req_q        <= req_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         be_q         <= be_d;
         pc_src_q     <= pc_src_d;
         target_q     <= target_d;
         wb_data_q    <= wb_data_d;
         wb_valid_q   <= wb_valid_d;
         misaligned_q <= misaligned_d;
         mem_error_q  <= mem_error_d;
         ld_load_q    <= ld_load_d;
         ld_signed_q  <= ld_signed_d;
         ld_width_q   <= ld_width_d;
         ld_lane_q    <= ld_lane_d;
      end
   end

   assign o_dmem_req      = req_q;
   assign o_dmem_we       = we_q;
   assign o_dmem_addr     = addr_q;
   assign o_dmem_wdata    = wdata_q;
   assign o_dmem_be       = be_q;
   assign o_pc_src        = pc_src_q;
   assign o_branch_target = target_q;
   assign o_wb_data       = wb_data_q;
   assign o_wb_valid      = wb_valid_q;
   assign o_misaligned    = misaligned_q;
   assign o_mem_error     = mem_error_q;

endmodule

// File: tb/tb_memory_access_unit.sv
// Self-checking bench for memory_access_unit: directed test-plan steps followed by
// randomized transactions checked against an arithmetic reference model.
module tb_memory_access_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_valid;
   logic [31:0] i_alu_result;
   logic        i_alu_zero;
   logic [31:0] i_branch_addr;
   logic [31:0] i_rt_data;
   logic        i_branch;
   logic        i_mem_read;
   logic        i_mem_write;
   logic [1:0]  i_mem_width;
   logic        i_load_signed;
   logic        i_dmem_ack;
   logic [31:0] i_dmem_rdata;
   logic        o_dmem_req;
   logic        o_dmem_we;
   logic [31:0] o_dmem_addr;
   logic [31:0] o_dmem_wdata;
   logic [3:0]  o_dmem_be;
   logic        o_stall;
   logic        o_pc_src;
   logic [31:0] o_branch_target;
   logic [31:0] o_wb_data;
   logic        o_wb_valid;
   logic        o_misaligned;
   logic        o_mem_error;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   memory_access_unit dut (
      .i_clock        (clk),
      .i_reset_n      (rst_n),
      .i_valid        (i_valid),
      .i_alu_result   (i_alu_result),
      .i_alu_zero     (i_alu_zero),
      .i_branch_addr  (i_branch_addr),
      .i_rt_data      (i_rt_data),
      .i_branch       (i_branch),
      .i_mem_read     (i_mem_read),
      .i_mem_write    (i_mem_write),
      .i_mem_width    (i_mem_width),
      .i_load_signed  (i_load_signed),
      .i_dmem_ack     (i_dmem_ack),
      .i_dmem_rdata   (i_dmem_rdata),
      .o_dmem_req     (o_dmem_req),
      .o_dmem_we      (o_dmem_we),
      .o_dmem_addr    (o_dmem_addr),
      .o_dmem_wdata   (o_dmem_wdata),
      .o_dmem_be      (o_dmem_be),
      .o_stall        (o_stall),
      .o_pc_src       (o_pc_src),
      .o_branch_target(o_branch_target),
      .o_wb_data      (o_wb_data),
      .o_wb_valid     (o_wb_valid),
      .o_misaligned   (o_misaligned),
      .o_mem_error    (o_mem_error)
   );

   // ---------------- reference model ----------------
   function automatic bit ref_aligned(input logic [1:0] w, input logic [31:0] a);
      case (w)
         2'd0:    return 1'b1;
         2'd1:    return (a % 2) == 0;
         2'd2:    return (a % 4) == 0;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] ref_be(input logic [1:0] w, input logic [31:0] a);
      int n;
      int m;
      n = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
      m = ((1 << n) - 1) << (a % 4);
      return m[3:0];
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [1:0] w, input logic [31:0] rt);
      if (w == 2'd0) return {24'b0, rt[7:0]} * 32'h0101_0101;
      if (w == 2'd1) return {16'b0, rt[15:0]} * 32'h0001_0001;
      return rt;
   endfunction

   function automatic logic [31:0] ref_load(input logic [1:0] w, input bit sgn,
                                            input logic [31:0] a, input logic [31:0] rdata);
      longint unsigned v;
      longint unsigned mask;
      int nb;
      nb   = (w == 2'd0) ? 8 : (w == 2'd1) ? 16 : 32;
      mask = (64'd1 << nb) - 1;
      v    = ({32'b0, rdata} >> (8 * (a % 4))) & mask;
      if (sgn && v[nb-1]) v = v | ~mask;
      return v[31:0];
   endfunction

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      i_valid = 0; i_alu_result = 0; i_alu_zero = 0; i_branch_addr = 0; i_rt_data = 0;
      i_branch = 0; i_mem_read = 0; i_mem_write = 0; i_mem_width = 0; i_load_signed = 0;
      i_dmem_ack = 0; i_dmem_rdata = 0;
   endtask

   task automatic do_alu(input logic [31:0] val);
      i_valid = 1; i_branch = 0; i_mem_read = 0; i_mem_write = 0; i_alu_result = val;
      #1 chk("alu_stall", 32'(o_stall), 0);
      step();
      chk("alu_wb_valid", 32'(o_wb_valid), 1);
      chk("alu_wb_data", o_wb_data, val);
      i_valid = 0;
      step();
      chk("alu_wb_pulse", 32'(o_wb_valid), 0);
   endtask

   task automatic do_branch(input bit zero, input logic [31:0] target, input bit rd, input bit wr);
      i_valid = 1; i_branch = 1; i_alu_zero = zero; i_branch_addr = target;
      i_mem_read = rd; i_mem_write = wr; i_mem_width = 2'd2; i_alu_result = 32'h3;
      #1 chk("br_stall", 32'(o_stall), 0);
      step();
      chk("br_pc_src", 32'(o_pc_src), 32'(zero));
      if (zero) chk("br_target", o_branch_target, target);
      chk("br_no_wb", 32'(o_wb_valid), 0);
      chk("br_no_req", 32'(o_dmem_req), 0);
      i_valid = 0; i_branch = 0; i_mem_read = 0; i_mem_write = 0;
      step();
      chk("br_pulse_end", 32'(o_pc_src), 0);
   endtask

   task automatic do_mem(input bit rd, input bit wr, input logic [1:0] w, input bit sgn,
                         input logic [31:0] addr, input logic [31:0] rt, input int waits,
                         input logic [31:0] rdata, input bit b2b);
      bit ok;
      bit load;
      int stalls;
      ok     = ref_aligned(w, addr);
      load   = rd && !wr;
      stalls = 0;
      i_valid = 1; i_branch = 0; i_mem_read = rd; i_mem_write = wr; i_mem_width = w;
      i_load_signed = sgn; i_alu_result = addr; i_rt_data = rt;
      #1;
      if (o_stall) stalls++;
      chk("mem_stall_issue", 32'(o_stall), 32'(ok));
      step();
      if (!ok) begin
         chk("mis_pulse", 32'(o_misaligned), 1);
         chk("mis_no_req", 32'(o_dmem_req), 0);
         chk("mis_no_wb", 32'(o_wb_valid), 0);
         i_valid = 0; i_mem_read = 0; i_mem_write = 0;
         #1 chk("mis_no_stall", 32'(o_stall), 0);
         step();
         chk("mis_pulse_end", 32'(o_misaligned), 0);
         return;
      end
      chk("req", 32'(o_dmem_req), 1);
      chk("we", 32'(o_dmem_we), 32'(wr));
      chk("addr", o_dmem_addr, addr & 32'hFFFF_FFFC);
      chk("be", 32'(o_dmem_be), 32'(ref_be(w, addr)));
      if (wr) chk("wdata", o_dmem_wdata, ref_wdata(w, rt));
      for (int i = 0; i < waits; i++) begin
         if (o_stall) stalls++;
         step();
         chk("req_hold", 32'(o_dmem_req), 1);
      end
      i_dmem_ack = 1; i_dmem_rdata = rdata;
      #1 chk("ack_stall", 32'(o_stall), 0);
      step();
      i_dmem_ack = 0; i_valid = 0; i_mem_read = 0; i_mem_write = 0;
      chk("req_drop", 32'(o_dmem_req), 0);
      chk("stall_cycles", stalls, waits + 1);
      chk("ld_wb_valid", 32'(o_wb_valid), 32'(load));
      if (load) chk("ld_wb_data", o_wb_data, ref_load(w, sgn, addr, rdata));
      if (!b2b) begin
         step();
         chk("wb_pulse_end", 32'(o_wb_valid), 0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int req_cycles;
      int stall_cycles;
      int kind;
      logic [31:0] r_addr;

      clear_inputs();
      rst_n = 0;
      #1;
      chk("rst_req", 32'(o_dmem_req), 0);
      chk("rst_stall", 32'(o_stall), 0);
      chk("rst_wb_valid", 32'(o_wb_valid), 0);
      chk("rst_mem_error", 32'(o_mem_error), 0);
      chk("rst_wb_data", o_wb_data, 0);
      step();
      step();
      rst_n = 1;
      step();

      // ALU pass-through and branches
      do_alu(32'h0000_1234);
      do_branch(1, 32'h0000_0040, 0, 0);
      do_branch(0, 32'h0000_0040, 0, 0);

      // signed / unsigned byte load at 0x103, ack after 3 WAIT cycles
      do_mem(1, 0, 2'd0, 1, 32'h0000_0103, 32'h0, 3, 32'h8000_0000, 0);
      chk("tp_signed_byte", o_wb_data, 32'hFFFF_FF80);
      do_mem(1, 0, 2'd0, 0, 32'h0000_0103, 32'h0, 3, 32'h8000_0000, 0);
      chk("tp_unsigned_byte", o_wb_data, 32'h0000_0080);

      // half store, misaligned word load, read+write treated as a store
      do_mem(0, 1, 2'd1, 0, 32'h0000_0022, 32'hABCD_1234, 1, 32'h0, 0);
      do_mem(1, 0, 2'd2, 0, 32'h0000_0102, 32'h0, 0, 32'h0, 0);
      do_mem(1, 1, 2'd2, 0, 32'h0000_0300, 32'hDEAD_BEEF, 2, 32'h1111_1111, 0);
      do_mem(1, 0, 2'd3, 0, 32'h0000_0300, 32'h0, 0, 32'h0, 0);

      // ack while idle is ignored
      i_dmem_ack = 1; i_dmem_rdata = 32'hCAFE_F00D;
      step();
      chk("idle_ack_wb", 32'(o_wb_valid), 0);
      chk("idle_ack_req", 32'(o_dmem_req), 0);
      i_dmem_ack = 0;

      // back-to-back: store, then a load presented the cycle after ack
      do_mem(0, 1, 2'd2, 0, 32'h0000_0400, 32'h0102_0304, 0, 32'h0, 1);
      do_mem(1, 0, 2'd1, 1, 32'h0000_0402, 32'h0, 1, 32'h8001_7FFF, 0);

      // timeout: ack never arrives
      i_valid = 1; i_mem_read = 1; i_mem_write = 0; i_mem_width = 2'd2; i_alu_result = 32'h200;
      #1;
      stall_cycles = o_stall ? 1 : 0;
      req_cycles = 0;
      step();
      while (o_dmem_req && req_cycles < 40) begin
         req_cycles++;
         if (o_stall) stall_cycles++;
         step();
      end
      i_valid = 0; i_mem_read = 0;
      chk("to_req_cycles", req_cycles, 15);
      chk("to_stall_cycles", stall_cycles, 15);
      chk("to_mem_error", 32'(o_mem_error), 1);
      chk("to_no_wb", 32'(o_wb_valid), 0);
      #1 chk("to_stall_released", 32'(o_stall), 0);
      do_alu(32'h0000_5678);
      chk("to_error_sticky", 32'(o_mem_error), 1);

      // reset mid-WAIT drops everything at once
      i_valid = 1; i_mem_read = 1; i_mem_width = 2'd2; i_alu_result = 32'h240;
      step();
      step();
      step();
      chk("mid_wait_req", 32'(o_dmem_req), 1);
      rst_n = 0;
      #1;
      chk("arst_req", 32'(o_dmem_req), 0);
      chk("arst_stall", 32'(o_stall), 0);
      chk("arst_be", 32'(o_dmem_be), 0);
      chk("arst_addr", o_dmem_addr, 0);
      chk("arst_mem_error", 32'(o_mem_error), 0);
      chk("arst_wb_data", o_wb_data, 0);
      i_valid = 0; i_mem_read = 0;
      step();
      rst_n = 1;
      step();
      step();
      chk("post_rst_wb", 32'(o_wb_valid), 0);
      chk("post_rst_err", 32'(o_mem_error), 0);

      // randomized transactions
      for (int t = 0; t < 40; t++) begin
         kind   = $urandom_range(0, 4);
         r_addr = $urandom;
         $display("txn %0d: kind=%0d addr=0x%08h", t, kind, r_addr);
         case (kind)
            0: do_alu($urandom);
            1: do_branch(1'($urandom_range(0, 1)), $urandom,
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            2: do_mem(1, 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), r_addr,
                      $urandom, $urandom_range(0, 5), $urandom, 1'($urandom_range(0, 1)));
            3: do_mem(0, 1, 2'($urandom_range(0, 3)), 0, r_addr,
                      $urandom, $urandom_range(0, 5), $urandom, 1'($urandom_range(0, 1)));
            default: do_mem(1, 1, 2'($urandom_range(0, 3)), 0, r_addr,
                            $urandom, $urandom_range(0, 5), $urandom, 1'($urandom_range(0, 1)));
         endcase
      end
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
